i2c_master_read_sequencer: RTL



---
 rtl/i2c_defs_pkg.sv | 24 ++
 rtl/i2c_rx_shift8.sv | 28 ++
 rtl/i2c_master_read_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_defs_pkg.sv
// Shared I2C read-sequencer definitions: state encodings, R/W and ACK bit constants.
package i2c_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_READ     = 3'd4,
    ST_MACK     = 3'd5,
    ST_STOP     = 3'd6,
    ST_FIN      = 3'd7
  } seq_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  // Address byte as it goes on the wire for a read.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, RW_READ};
  endfunction

endpackage

// File: rtl/i2c_rx_shift8.sv
// 8-bit MSB-first receive shifter; data_c is the value including any bit loaded this cycle.
module i2c_rx_shift8 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       bit_i,
  output logic [7:0] data_c
);

  logic [7:0] data_q;
  logic [7:0] base_c;

  // Clear takes priority so a new byte always starts from zero.
  always_comb begin
    base_c = clear_i ? 8'h00 : data_q;
    data_c = load_i ? {base_c[6:0], bit_i} : base_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_c;
    end
  end

endmodule

// File: rtl/i2c_master_read_sequencer.sv
// I2C master read transaction sequencer: START, address+R, ACK check, N bytes with ACK/NACK, STOP.
// Optional per-phase watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_read_sequencer
  import i2c_defs_pkg::*;
#(
  parameter int unsigned LEN_W = 8
`ifdef I2C_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             nack,
  output logic             error,
  output logic             busy,
  output logic             start_go,
  input  logic             start_finish,
  output logic             wr_go,
  output logic [7:0]       wr_data,
  input  logic             wr_finish,
  input  logic             wr_error,
  output logic             ack_rd_go,
  input  logic             ack_rd_finish,
  input  logic             ack_rd_value,
  output logic             rd_go,
  input  logic             rd_bit,
  input  logic             rd_load,
  input  logic             rd_finish,
  input  logic             rd_error,
  output logic             ack_wr_go,
  output logic             ack_wr_value,
  input  logic             ack_wr_finish,
  output logic             stop_go,
  input  logic             stop_finish
);

  seq_state_e       state_q;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remaining_q;
  logic [7:0]       shift_c;
  logic             timeout_c;

  // Shifter only accepts bits inside READ and is held at zero everywhere else.
  i2c_rx_shift8 u_rx_shift8 (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (state_q != ST_READ),
    .load_i  ((state_q == ST_READ) && rd_load),
    .bit_i   (rd_bit),
    .data_c  (shift_c)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e      seen_q;
  logic [TO_W-1:0] phase_q;
  logic [TO_W-1:0] dwell_c;
  logic            holding_go_c;

  // Dwell count restarts whenever the state differs from the previous cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seen_q  <= ST_IDLE;
      phase_q <= '0;
    end else begin
      seen_q  <= state_q;
      phase_q <= (state_q != seen_q) ? TO_W'(1) : phase_q + TO_W'(1);
    end
  end

  assign dwell_c      = (state_q != seen_q) ? '0 : phase_q;
  assign holding_go_c = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign timeout_c    = holding_go_c && (dwell_c == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      done         <= 1'b0;
      nack         <= 1'b0;
      error        <= 1'b0;
      start_go     <= 1'b0;
      wr_go        <= 1'b0;
      wr_data      <= 8'h00;
      ack_rd_go    <= 1'b0;
      rd_go        <= 1'b0;
      ack_wr_go    <= 1'b0;
      ack_wr_value <= ACK_BIT;
      stop_go      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            nack      <= 1'b0;
            error     <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            start_go  <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (start_finish) begin
            start_go <= 1'b0;
            wr_data  <= addr_byte(addr_q);
            wr_go    <= 1'b1;
            state_q  <= ST_ADDR;
          end else if (timeout_c) begin
            start_go <= 1'b0;
            error    <= 1'b1;
            stop_go  <= 1'b1;
            state_q  <= ST_STOP;
          end
        end
        ST_ADDR: begin
          if (wr_error || timeout_c) begin
            wr_go   <= 1'b0;
            error   <= 1'b1;
            stop_go <= 1'b1;
            state_q <= ST_STOP;
          end else if (wr_finish) begin
            wr_go     <= 1'b0;
            ack_rd_go <= 1'b1;
            state_q   <= ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (ack_rd_finish) begin
            ack_rd_go <= 1'b0;
            if (ack_rd_value == NACK_BIT) begin
              nack    <= 1'b1;
              stop_go <= 1'b1;
              state_q <= ST_STOP;
            end else if (len_q == '0) begin
              stop_go <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              remaining_q <= len_q;
              rd_go       <= 1'b1;
              state_q     <= ST_READ;
            end
          end else if (timeout_c) begin
            ack_rd_go <= 1'b0;
            error     <= 1'b1;
            stop_go   <= 1'b1;
            state_q   <= ST_STOP;
          end
        end
        ST_READ: begin
          if (rd_error || timeout_c) begin
            rd_go   <= 1'b0;
            error   <= 1'b1;
            stop_go <= 1'b1;
            state_q <= ST_STOP;
          end else if (rd_finish) begin
            // Final byte (remaining about to reach zero) is answered with NACK.
            rd_go        <= 1'b0;
            rx_data      <= shift_c;
            rx_valid     <= 1'b1;
            remaining_q  <= remaining_q - LEN_W'(1);
            ack_wr_value <= (remaining_q == LEN_W'(1)) ? NACK_BIT : ACK_BIT;
            ack_wr_go    <= 1'b1;
            state_q      <= ST_MACK;
          end
        end
        ST_MACK: begin
          if (ack_wr_finish) begin
            ack_wr_go <= 1'b0;
            if (remaining_q != '0) begin
              rd_go   <= 1'b1;
              state_q <= ST_READ;
            end else begin
              stop_go <= 1'b1;
              state_q <= ST_STOP;
            end
          end else if (timeout_c) begin
            ack_wr_go <= 1'b0;
            error     <= 1'b1;
            stop_go   <= 1'b1;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (stop_finish) begin
            stop_go <= 1'b0;
            state_q <= ST_FIN;
          end else if (timeout_c) begin
            stop_go <= 1'b0;
            error   <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
